// File: rtl/uart_tx_hold.sv
// UART transmitter with a one-word host holding register and full flag.
// Frames each held word as start, DBIT data bits LSB first, stop, paced by s_tick.
module uart_tx_hold #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx_full,
    output logic            tx,
    output logic            tx_done_tick
);

    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]      r_state, w_state_next;
    logic [SW-1:0]   r_s, w_s_next;
    logic [NW-1:0]   r_n, w_n_next;
    logic [DBIT-1:0] r_shift, w_shift_next;
    logic [DBIT-1:0] r_hold, w_hold_next;
    logic            r_full, w_full_next;
    logic            r_tx, w_tx_next;
    logic            w_load;
    logic            w_done;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_hold  <= '0;
            r_full  <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_shift <= w_shift_next;
            r_hold  <= w_hold_next;
            r_full  <= w_full_next;
            r_tx    <= w_tx_next;
        end
    end

    // Next-state, framing and holding-register logic
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_shift_next = r_shift;
        w_hold_next  = r_hold;
        w_full_next  = r_full;
        w_tx_next    = r_tx;
        w_load       = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (r_full) begin
                    w_load       = 1'b1;
                    w_shift_next = r_hold;
                    w_s_next     = '0;
                    w_tx_next    = 1'b0;
                    w_state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == SW'(15)) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_tx_next    = r_shift[0];
                        w_state_next = DATA;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == SW'(15)) begin
                        w_s_next     = '0;
                        w_shift_next = r_shift >> 1;
                        if (r_n == NW'(DBIT - 1)) begin
                            w_tx_next    = 1'b1;
                            w_state_next = STOP;
                        end else begin
                            w_n_next  = r_n + NW'(1);
                            w_tx_next = r_shift[1];
                        end
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_done       = 1'b1;
                        w_s_next     = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A write coinciding with the load still sees the flag set and is dropped
        if (w_load) begin
            w_full_next = 1'b0;
        end else if (wr_uart && !r_full) begin
            w_hold_next = w_data;
            w_full_next = 1'b1;
        end
    end

    assign tx_full      = r_full;
    assign tx           = r_tx;
    assign tx_done_tick = w_done;

endmodule

// File: tb/tb_uart_tx_hold.sv
// Self-checking bench for uart_tx_hold: a serial decoder on tx pops expected
// words from a scoreboard queue; directed checks cover flags, timing and reset.
`timescale 1ns/1ps
module tb_uart_tx_hold;

    localparam int unsigned DBIT    = 8;
    localparam int unsigned FRAME16 = 16 * (1 + DBIT) + 16;
    localparam int unsigned FRAME32 = 16 * (1 + DBIT) + 32;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       s_tick  = 1'b0;
    logic       wr_uart = 1'b0;
    logic [7:0] w_data  = '0;
    logic       tx_full, tx, tx_done_tick;

    logic       wr32 = 1'b0;
    logic [7:0] d32  = '0;
    logic       full32, tx32, done32;

    logic        stall = 1'b0;
    int unsigned div   = 0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  q[$];

    int unsigned cyc     = 0;
    int unsigned ndone   = 0;
    int unsigned nframes = 0;
    int unsigned mon_k   = 0;
    bit          busy    = 1'b0;

    always #5 clk = ~clk;

    uart_tx_hold #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .wr_uart      (wr_uart),
        .w_data       (w_data),
        .tx_full      (tx_full),
        .tx           (tx),
        .tx_done_tick (tx_done_tick)
    );

    uart_tx_hold #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .wr_uart      (wr32),
        .w_data       (d32),
        .tx_full      (full32),
        .tx           (tx32),
        .tx_done_tick (done32)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Baud tick: one pulse every 4 clk unless stalled
    always @(posedge clk) begin
        #1;
        div    = (div == 3) ? 0 : div + 1;
        s_tick = (div == 3) && !stall;
    end

    task automatic send(input logic [7:0] d, input bit accept);
        @(posedge clk); #1;
        wr_uart = 1'b1;
        w_data  = d;
        @(posedge clk); #1;
        wr_uart = 1'b0;
        if (accept) q.push_back(d);
    endtask

    task automatic wait_frames(input int unsigned target, input string tag);
        int unsigned t = 0;
        while (nframes < target || busy) begin
            @(negedge clk); #1;
            t++;
            if (t > 6000) begin
                check(tag, 32'd0, 32'd1);
                return;
            end
        end
    endtask

    // Serial decoder: samples each bit mid-period and checks the done pulse
    initial begin : monitor
        int unsigned b;
        logic [7:0]  got;
        logic [7:0]  exp_d;
        got = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_done_tick === 1'b1) ndone++;
            if (!reset) begin
                busy = 1'b0;
            end else if (!busy && tx === 1'b0) begin
                busy  = 1'b1;
                mon_k = 0;
                got   = '0;
                nframes++;
            end
            if (busy && s_tick) begin
                mon_k++;
                check("done_tick", 32'(tx_done_tick), 32'(mon_k == FRAME16));
                if (mon_k % 16 == 8) begin
                    b = mon_k / 16;
                    if (b == 0) check("start_bit", 32'(tx), 32'd0);
                    else if (b <= DBIT) got[b-1] = tx;
                    else check("stop_bit", 32'(tx), 32'd1);
                end
                if (mon_k == FRAME16) begin
                    busy = 1'b0;
                    if (q.size() == 0) begin
                        check("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
                    end else begin
                        exp_d = q.pop_front();
                        check("rx_data", 32'(got), 32'(exp_d));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned nf0, nd0, t, k32;
        bit          started;
        logic [9:0]  fb;

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",   32'(tx),           32'd1);
        check("rst_full", 32'(tx_full),      32'd0);
        check("rst_done", 32'(tx_done_tick), 32'd0);
        @(negedge clk); #2 reset = 1'b1;
        repeat (10) @(posedge clk);

        // single frame
        nf0 = nframes; nd0 = ndone;
        send(8'hA5, 1'b1);
        check("t2_full_set", 32'(tx_full), 32'd1);
        check("t2_tx_idle",  32'(tx),      32'd1);
        @(posedge clk); #1;
        check("t2_full_clr", 32'(tx_full), 32'd0);
        check("t2_tx_start", 32'(tx),      32'd0);
        wait_frames(nf0 + 1, "t2_timeout");
        check("t2_ndone", ndone - nd0, 32'd1);

        // back-to-back with a word held during DATA
        nf0 = nframes; nd0 = ndone;
        send(8'h55, 1'b1);
        repeat (150) @(posedge clk);
        send(8'h0F, 1'b1);
        check("t3_full_held", 32'(tx_full), 32'd1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (tx_done_tick !== 1'b1 && t < 2000);
        check("t3_done_seen",    32'(tx_done_tick), 32'd1);
        check("t3_full_at_done", 32'(tx_full),      32'd1);
        @(negedge clk);
        check("t3_gap_tx",   32'(tx),      32'd1);
        check("t3_gap_full", 32'(tx_full), 32'd1);
        @(negedge clk);
        check("t3_load_tx",   32'(tx),      32'd0);
        check("t3_load_full", 32'(tx_full), 32'd0);
        wait_frames(nf0 + 2, "t3_timeout");
        check("t3_ndone", ndone - nd0, 32'd2);

        // overflow: third write while full is dropped
        nf0 = nframes; nd0 = ndone;
        send(8'h11, 1'b1);
        repeat (100) @(posedge clk);
        send(8'h22, 1'b1);
        repeat (100) @(posedge clk);
        send(8'h33, 1'b0);
        check("t4_full", 32'(tx_full), 32'd1);
        wait_frames(nf0 + 2, "t4_timeout");
        repeat (1500) @(posedge clk);
        check("t4_ndone",   ndone - nd0,   32'd2);
        check("t4_nframes", nframes - nf0, 32'd2);
        check("t4_full_end", 32'(tx_full), 32'd0);

        // collision: write during the load cycle is dropped
        nf0 = nframes;
        @(posedge clk); #1;
        wr_uart = 1'b1;
        w_data  = 8'h3C;
        @(posedge clk); #1;
        w_data  = 8'h77;
        check("t5_full_set", 32'(tx_full), 32'd1);
        @(posedge clk); #1;
        wr_uart = 1'b0;
        check("t5_full_clr", 32'(tx_full), 32'd0);
        check("t5_tx_start", 32'(tx),      32'd0);
        q.push_back(8'h3C);
        wait_frames(nf0 + 1, "t5_timeout");
        repeat (800) @(posedge clk);
        check("t5_nframes", nframes - nf0, 32'd1);

        // stall in DATA: tx frozen at the bit the decoder is in
        nf0 = nframes;
        fb  = {1'b1, 8'hC6, 1'b0};
        send(8'hC6, 1'b1);
        repeat (200) @(posedge clk);
        #2 stall = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("t6_stall_tx",   32'(tx),           32'(fb[mon_k / 16]));
            check("t6_stall_done", 32'(tx_done_tick), 32'd0);
        end
        stall = 1'b0;
        wait_frames(nf0 + 1, "t6_timeout");

        // reset mid-frame with a second word held
        send(8'h3C, 1'b1);
        repeat (300) @(posedge clk);
        send(8'hC3, 1'b1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("t1_tx",   32'(tx),           32'd1);
        check("t1_full", 32'(tx_full),      32'd0);
        check("t1_done", 32'(tx_done_tick), 32'd0);
        @(negedge clk);
        @(negedge clk);
        q.delete();
        #2 reset = 1'b1;
        nf0 = nframes; nd0 = ndone;
        repeat (1000) @(posedge clk);
        #1;
        check("t1_nframes", nframes - nf0, 32'd0);
        check("t1_ndone",   ndone - nd0,   32'd0);
        check("t1_idle_tx", 32'(tx),       32'd1);

        // two-stop-bit instance: frame spans 176 ticks
        @(posedge clk); #1;
        wr32 = 1'b1;
        d32  = 8'h81;
        @(posedge clk); #1;
        wr32 = 1'b0;
        t = 0; k32 = 0; started = 1'b0;
        while (t < 3000) begin
            @(negedge clk);
            t++;
            if (!started && tx32 === 1'b0) started = 1'b1;
            if (started && s_tick) begin
                k32++;
                if (k32 == 16 * (1 + DBIT) + 24) check("sb32_stop_late", 32'(tx32), 32'd1);
                if (done32 === 1'b1) break;
            end
        end
        check("sb32_ticks", k32, FRAME32);
        check("sb32_done",  32'(done32), 32'd1);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
